// File: rtl/bram_pkg.sv
// Shared types and defaults for the simple-dual-port RAM with clear sequencer.
package bram_pkg;

  typedef enum logic {StClear, StReady} state_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 8;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Pure storage array: masked write, read-first registered read, no reset on the array.
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_wmask,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Mask bit set keeps the stored bit.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= (r_mem[i_waddr] & i_wmask) | (i_wdata & ~i_wmask);
    end
  end

  // Non-blocking update of the array makes a same-address read return old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_sdp_clr.sv
// SDP RAM with reset-driven clear sweep and read-valid strobe.
// Define BRAM_SDP_OUTREG_EN to add an output register stage (2-cycle read latency).
module bram_sdp_clr
  import bram_pkg::*;
#(
  parameter int unsigned            DATA_W    = DefDataW,
  parameter int unsigned            ADDR_W    = DefAddrW,
  parameter logic [DATA_W-1:0]      CLR_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_wclke,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_wmask,
  input  logic              i_re,
  input  logic              i_rclke,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy
);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_ptr, w_ptr_d;
  logic              r_rvalid;

  logic              w_core_we;
  logic [ADDR_W-1:0] w_core_waddr;
  logic [DATA_W-1:0] w_core_wdata;
  logic [DATA_W-1:0] w_core_wmask;
  logic              w_core_re;
  logic [DATA_W-1:0] w_core_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StClear;
      r_ptr    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ptr    <= w_ptr_d;
      r_rvalid <= w_core_re;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_core_we    = 1'b0;
    w_core_waddr = i_waddr;
    w_core_wdata = i_wdata;
    w_core_wmask = i_wmask;
    w_core_re    = 1'b0;
    unique case (r_state)
      StClear: begin
        w_core_we    = 1'b1;
        w_core_waddr = r_ptr;
        w_core_wdata = CLR_VALUE;
        w_core_wmask = '0;
        w_ptr_d      = r_ptr + ADDR_W'(1);
        // Explicit last-address compare: the sweep ends here rather than wrapping.
        if (r_ptr == {ADDR_W{1'b1}}) begin
          w_state_d = StReady;
        end
      end
      StReady: begin
        w_core_we = i_we & i_wclke;
        w_core_re = i_re & i_rclke;
      end
    endcase
    if (i_rst) begin
      w_core_we = 1'b0;
      w_core_re = 1'b0;
    end
  end

  bram_sdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_core_we),
    .i_waddr (w_core_waddr),
    .i_wdata (w_core_wdata),
    .i_wmask (w_core_wmask),
    .i_re    (w_core_re),
    .i_raddr (i_raddr),
    .o_rdata (w_core_rdata)
  );

  assign o_busy = (r_state == StClear);

`ifdef BRAM_SDP_OUTREG_EN
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rvalid2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata2  <= '0;
      r_rvalid2 <= 1'b0;
    end else begin
      r_rvalid2 <= r_rvalid;
      if (r_rvalid) begin
        r_rdata2 <= w_core_rdata;
      end
    end
  end

  assign o_rdata  = r_rdata2;
  assign o_rvalid = r_rvalid2;
`else
  assign o_rdata  = w_core_rdata;
  assign o_rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Self-checking bench for bram_sdp_clr: two instances (clear value 0 and 0x00C3) share stimulus.
module tb_bram_sdp_clr;

`ifdef BRAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, we, wclke, re, rclke;
  logic [7:0]  waddr, raddr;
  logic [15:0] wdata, wmask;
  logic [15:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_sdp_clr #(.DATA_W(16), .ADDR_W(8), .CLR_VALUE(16'h0000)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wclke(wclke), .i_waddr(waddr),
    .i_wdata(wdata), .i_wmask(wmask), .i_re(re), .i_rclke(rclke), .i_raddr(raddr),
    .o_rdata(rdata0), .o_rvalid(rvalid0), .o_busy(busy0)
  );

  bram_sdp_clr #(.DATA_W(16), .ADDR_W(8), .CLR_VALUE(16'h00C3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wclke(wclke), .i_waddr(waddr),
    .i_wdata(wdata), .i_wmask(wmask), .i_re(re), .i_rclke(rclke), .i_raddr(raddr),
    .o_rdata(rdata1), .o_rvalid(rvalid1), .o_busy(busy1)
  );

  // Reference model: memory contents plus a read-result pipeline of LAT stages.
  logic [15:0] m0 [256];
  logic [15:0] m1 [256];
  int          ptr = 0;
  bit          mbusy = 1'b1;
  logic [15:0] s1_d0 = '0, s1_d1 = '0, s2_d0 = '0, s2_d1 = '0;
  bit          s1_v = 1'b0, s2_v = 1'b0;

  function automatic logic [15:0] exp_d0();
    return (LAT == 2) ? s2_d0 : s1_d0;
  endfunction
  function automatic logic [15:0] exp_d1();
    return (LAT == 2) ? s2_d1 : s1_d1;
  endfunction
  function automatic logic exp_v();
    return (LAT == 2) ? s2_v : s1_v;
  endfunction

  task automatic idle();
    we = 0; wclke = 0; waddr = '0; wdata = '0; wmask = '0;
    re = 0; rclke = 0; raddr = '0;
  endtask

  // Apply current inputs for one clock edge, advancing the model alongside.
  task automatic step();
    bit rd;
    if (rst) begin
      ptr = 0; mbusy = 1'b1;
      s1_v = 0; s2_v = 0; s1_d0 = '0; s1_d1 = '0; s2_d0 = '0; s2_d1 = '0;
    end else begin
      rd = !mbusy && re && rclke;
      if (s1_v) begin
        s2_d0 = s1_d0; s2_d1 = s1_d1;
      end
      s2_v = s1_v;
      s1_v = rd;
      if (rd) begin
        s1_d0 = m0[raddr]; s1_d1 = m1[raddr];
      end
      if (mbusy) begin
        m0[ptr] = 16'h0000; m1[ptr] = 16'h00C3;
        ptr++;
        if (ptr == 256) mbusy = 1'b0;
      end else if (we && wclke) begin
        m0[waddr] = (m0[waddr] & wmask) | (wdata & ~wmask);
        m1[waddr] = (m1[waddr] & wmask) | (wdata & ~wmask);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] mk);
    idle(); we = 1; wclke = 1; waddr = a; wdata = d; wmask = mk;
    step();
    idle();
  endtask

  // Issue one enabled read and wait until its data should be on the outputs.
  task automatic do_read(input logic [7:0] a);
    idle(); re = 1; rclke = 1; raddr = a;
    step();
    idle();
    repeat (LAT - 1) step();
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] addrs [3];
    idle(); rst = 1;
    step(); step();
    checks++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, want 1 0 0000", busy0, rvalid0, rdata0);
    end
    rst = 0;
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      re = 1; rclke = 1; raddr = 8'(n);
      step();
      n++;
      checks++;
      if (rvalid0 !== 1'b0) begin
        errors++;
        $display("FAIL clear_read_dropped: rvalid=%b at cycle %0d, want 0", rvalid0, n);
      end
    end
    idle();
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_length: busy cycles=%0d, want 256", n);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_dut1: busy=%b, want 0", busy1);
    end
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i]);
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 16'h0000 || rdata1 !== 16'h00C3) begin
        errors++;
        $display("FAIL clear_read[%h]: rvalid=%b rdata0=%h rdata1=%h, want 1 0000 00C3",
                 addrs[i], rvalid0, rdata0, rdata1);
      end
      step();
      checks++;
      if (rvalid0 !== 1'b0) begin
        errors++;
        $display("FAIL rvalid_strobe[%h]: rvalid=%b, want 0", addrs[i], rvalid0);
      end
    end
  endtask

  task automatic test_masked_write();
    do_write(8'h10, 16'hFFFF, 16'h0000);
    do_write(8'h10, 16'h1234, 16'hFF00);
    idle(); re = 1; rclke = 1; raddr = 8'h10;
    step();
    idle();
    checks++;
    if (rvalid0 !== exp_v()) begin
      errors++;
      $display("FAIL masked_latency: rvalid=%b one cycle after re, want %b", rvalid0, exp_v());
    end
    repeat (LAT - 1) step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'hFF34 || rdata1 !== 16'hFF34) begin
      errors++;
      $display("FAIL masked_write: rvalid=%b rdata0=%h rdata1=%h, want 1 FF34 FF34",
               rvalid0, rdata0, rdata1);
    end
  endtask

  task automatic test_read_during_write();
    do_write(8'h20, 16'hAAAA, 16'h0000);
    idle(); we = 1; wclke = 1; waddr = 8'h20; wdata = 16'h5555;
    re = 1; rclke = 1; raddr = 8'h20;
    step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'hAAAA) begin
      errors++;
      $display("FAIL rdw_old: rvalid=%b rdata=%h, want 1 AAAA", rvalid0, rdata0);
    end
    do_read(8'h20);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'h5555) begin
      errors++;
      $display("FAIL rdw_new: rvalid=%b rdata=%h, want 1 5555", rvalid0, rdata0);
    end
  endtask

  task automatic test_enable_gating();
    idle(); step(); step();
    we = 1; wclke = 0; waddr = 8'h30; wdata = 16'hBEEF;
    step();
    idle(); re = 1; rclke = 0; raddr = 8'h30;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== 16'h5555) begin
        errors++;
        $display("FAIL gated_read[%0d]: rvalid=%b rdata=%h, want 0 5555", i, rvalid0, rdata0);
      end
    end
    do_read(8'h30);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'h0000 || rdata1 !== 16'h00C3) begin
      errors++;
      $display("FAIL gated_write: rvalid=%b rdata0=%h rdata1=%h, want 1 0000 00C3",
               rvalid0, rdata0, rdata1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom); wclke = 1'($urandom); waddr = 8'($urandom_range(0, 15));
      wdata = 16'($urandom); wmask = 16'($urandom);
      re = 1'($urandom); rclke = 1'($urandom); raddr = 8'($urandom_range(0, 15));
      step();
      checks++;
      if (rvalid0 !== exp_v() || rdata0 !== exp_d0() || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL random0[%0d]: rvalid=%b rdata=%h busy=%b, want %b %h 0",
                 i, rvalid0, rdata0, busy0, exp_v(), exp_d0());
      end
      checks++;
      if (rvalid1 !== exp_v() || rdata1 !== exp_d1()) begin
        errors++;
        $display("FAIL random1[%0d]: rvalid=%b rdata=%h, want %b %h",
                 i, rvalid1, rdata1, exp_v(), exp_d1());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [7:0] a;
    idle(); rst = 1; step(); rst = 0;
    repeat (100) step();
    rst = 1; step();
    checks++;
    if (busy1 !== 1'b1 || rvalid1 !== 1'b0 || rdata1 !== 16'h0) begin
      errors++;
      $display("FAIL midclear_reset: busy=%b rvalid=%b rdata=%h, want 1 0 0000",
               busy1, rvalid1, rdata1);
    end
    rst = 0;
    n = 0;
    while (busy1 === 1'b1 && n < 400) begin
      we = 1; wclke = 1; waddr = 8'($urandom); wdata = 16'($urandom); wmask = '0;
      step();
      n++;
    end
    idle();
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL midclear_length: busy cycles=%0d, want 256", n);
    end
    for (int i = 0; i < 20; i++) begin
      a = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h05 : 8'($urandom);
      do_read(a);
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 16'h00C3 || rdata0 !== 16'h0000) begin
        errors++;
        $display("FAIL midclear_read[%h]: rvalid=%b rdata1=%h rdata0=%h, want 1 00C3 0000",
                 a, rvalid1, rdata1, rdata0);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_masked_write();
    test_read_during_write();
    test_enable_gating();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
